// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, defaults and helpers for the FIFO write arbiter
`ifndef DEF_FIFO_WIDTH
`define DEF_FIFO_WIDTH 8
`endif
`ifndef DEF_FIFO_DEPTH
`define DEF_FIFO_DEPTH 16
`endif

package fifo_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 4;

    // Wide enough to hold every value 0..depth inclusive.
    function automatic int CREDIT_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner select, scanning from last+1
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_req
);

    localparam int OW = $clog2(NUM_REQ);

    logic [OW-1:0] idx;

    // Scan farthest-first so the candidate nearest to last+1 overwrites the rest.
    always_comb begin
        winner = last;
        idx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = OW'((int'(last) + i) % NUM_REQ);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port, credit-protected
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = `DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = `DEF_FIFO_DEPTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]                gnt,
    output logic                              fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]             fifo_data_in,
    input  logic                              fifo_full,
    input  logic                              fifo_rd_en,
    input  logic                              fifo_empty,
    output logic [CREDIT_W(FIFO_DEPTH)-1:0]   credits,
    output logic [$clog2(NUM_REQ)-1:0]        owner
);

    localparam int CW = CREDIT_W(FIFO_DEPTH);
    localparam int OW = $clog2(NUM_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [CW-1:0] FULL_CREDITS = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BEAT    = BW'(MAX_BURST - 1);
    localparam logic [OW-1:0] LAST_REQ     = OW'(NUM_REQ - 1);

    arb_state_e           state;
    logic [BW-1:0]        burst_cnt;
    logic [OW-1:0]        winner;
    logic                 any_req;
    logic                 has_credit;
    logic                 own_req;
    logic                 transfer;
    logic                 rd_ret;
    logic [FIFO_WIDTH-1:0] words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign words[i] = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (req),
        .last    (owner),
        .winner  (winner),
        .any_req (any_req)
    );

    assign has_credit = (credits != '0);
    assign own_req    = req[owner];
    assign transfer   = (state == BURST) && own_req && has_credit && !fifo_full;
    assign rd_ret     = fifo_rd_en && !fifo_empty;

    always_comb begin
        gnt        = '0;
        gnt[owner] = transfer;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= LAST_REQ;
            burst_cnt    <= '0;
            credits      <= FULL_CREDITS;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
        end else begin
            fifo_wr_en <= transfer;
            if (transfer) begin
                fifo_data_in <= words[owner];
            end

            // A write and a returned slot in the same cycle cancel out.
            case ({transfer, rd_ret})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase

            case (state)
                IDLE: begin
                    if (any_req && has_credit) begin
                        owner     <= winner;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (!own_req) begin
                        state <= IDLE;
                    end else if (transfer) begin
                        burst_cnt <= burst_cnt + BW'(1);
                        if (burst_cnt == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_credit_range: assert property (@(posedge clk) disable iff (rst)
        credits <= FULL_CREDITS);

    a_credit_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rd_ret && !transfer && credits == FULL_CREDITS));

endmodule
